masked_subbytes_seq: RTL

- Byte-serial SubBytes sequencer. Sits directly upstream and downstream of the pipelined masked S-box, `aes_sbox` (PIPELINED=1).
- Accepts one fully shared 128-bit AES state and streams its 16 shared bytes into the S-box, one byte per cycle, gated by the availability of fresh randomness.
- Tracks in-flight bytes through the S-box pipeline and reassembles the shared outputs into a shared 128-bit result.
- Never recombines shares; works for any share count.

---
 rtl/aes_masked_pkg.sv | 20 ++
 rtl/valid_delay_line.sv | 24 ++
 rtl/masked_subbytes_seq.sv | 131 +++++++++++++
 3 files changed

// File: rtl/aes_masked_pkg.sv
// Shared definitions for the masked AES datapath: byte counts, default S-box
// latency, sequencer state encoding and the shared-state byte indexing helper.
package aes_masked_pkg;

    localparam int NBYTES               = 16;
    localparam int DEFAULT_SBOX_LATENCY = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    // LSB of byte k of share i inside a 128*SHARES shared state vector.
    function automatic int SHARED_BYTE_LSB(input int i, input int k);
        return i * 128 + 8 * k;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// DEPTH-stage shift register carrying a 1-bit strobe alongside a fixed-latency
// pipeline; the asynchronous clear discards anything in flight.
module valid_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_strobe,
    output logic o_strobe
);

    logic [DEPTH-1:0] r_line;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_line <= '0;
        end else begin
            r_line <= (r_line << 1) | DEPTH'(i_strobe);
        end
    end

    assign o_strobe = r_line[DEPTH-1];

endmodule

// File: rtl/masked_subbytes_seq.sv
// Byte-serial SubBytes sequencer around a pipelined masked S-box.
// Shares are never recombined; a byte is issued only when fresh randomness is present.
//
// state | meaning
// IDLE  | waiting for a shared state
// FEED  | issuing bytes to the S-box, one per cycle with randomness
// DRAIN | all bytes issued, collecting the remaining S-box results
// DONE  | result valid, waiting for the consumer
module masked_subbytes_seq
    import aes_masked_pkg::*;
#(
    parameter int SHARES  = 2,
    parameter int LATENCY = DEFAULT_SBOX_LATENCY
) (
    input  logic                    ClkxCI,
    input  logic                    RstxRI,
    input  logic                    InValidxSI,
    output logic                    InReadyxSO,
    input  logic [128*SHARES-1:0]   StatexDI,
    input  logic                    RndValidxSI,
    output logic                    RndReadyxSO,
    output logic [8*SHARES-1:0]     SboxXxDO,
    input  logic [8*SHARES-1:0]     SboxQxDI,
    output logic                    OutValidxSO,
    input  logic                    OutReadyxSI,
    output logic [128*SHARES-1:0]   StatexDO,
    output logic                    BusyxSO
);

    localparam logic [3:0] LAST_BYTE = 4'(NBYTES - 1);

    seq_state_e              r_fsm;
    seq_state_e              w_fsm_nxt;
    logic [128*SHARES-1:0]   r_state;
    logic [128*SHARES-1:0]   r_result;
    logic [3:0]              r_issue_ptr;
    logic [3:0]              r_write_ptr;
    logic                    w_issue;
    logic                    w_write;
    logic                    w_capture;

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        InReadyxSO  = 1'b0;
        OutValidxSO = 1'b0;
        BusyxSO     = 1'b1;
        case (r_fsm)
            ST_IDLE: begin
                InReadyxSO = 1'b1;
                BusyxSO    = 1'b0;
                if (InValidxSI) begin
                    w_capture = 1'b1;
                    w_fsm_nxt = ST_FEED;
                end
            end
            ST_FEED: begin
                w_issue = RndValidxSI;
                if (RndValidxSI && (r_issue_ptr == LAST_BYTE)) begin
                    w_fsm_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_write && (r_write_ptr == LAST_BYTE)) begin
                    w_fsm_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                OutValidxSO = 1'b1;
                if (OutReadyxSI) begin
                    w_fsm_nxt = ST_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = ST_IDLE;
            end
        endcase
    end

    assign RndReadyxSO = w_issue;

    // Zero default keeps captured bytes off the S-box input outside their issue cycle.
    always_comb begin
        SboxXxDO = '0;
        if (w_issue) begin
            for (int i = 0; i < SHARES; i++) begin
                SboxXxDO[i*8 +: 8] = r_state[SHARED_BYTE_LSB(i, int'(r_issue_ptr)) +: 8];
            end
        end
    end

    valid_delay_line #(
        .DEPTH (LATENCY)
    ) u_valid_dly (
        .i_clk    (ClkxCI),
        .i_rst    (RstxRI),
        .i_strobe (w_issue),
        .o_strobe (w_write)
    );

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            r_fsm       <= ST_IDLE;
            r_state     <= '0;
            r_result    <= '0;
            r_issue_ptr <= '0;
            r_write_ptr <= '0;
        end else begin
            r_fsm <= w_fsm_nxt;
            if (w_capture) begin
                r_state     <= StatexDI;
                r_issue_ptr <= '0;
                r_write_ptr <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_ptr <= r_issue_ptr + 4'd1;
                end
                if (w_write) begin
                    for (int i = 0; i < SHARES; i++) begin
                        r_result[SHARED_BYTE_LSB(i, int'(r_write_ptr)) +: 8] <= SboxQxDI[i*8 +: 8];
                    end
                    r_write_ptr <= r_write_ptr + 4'd1;
                end
            end
        end
    end

    assign StatexDO = r_result;

endmodule
